// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and timing helpers for the button event decoder.
//               Holds the gesture state encoding and the default tick counts
//               derived from a 100 MHz clock.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Gesture states; explicit 3-bit width keeps the encoding stable.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        WAIT2  = 3'd3,
        PRESS2 = 3'd4
    } btn_state_t;

    localparam int unsigned CLK_HZ    = 100_000_000;
    localparam int unsigned LONG_MS   = 1000;
    localparam int unsigned DCLICK_MS = 300;

    // Converts a duration in milliseconds into clk cycles at CLK_HZ.
    function automatic int unsigned ms_to_ticks(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Rise/fall detector for a clk-synchronous level. The first clk
//               edge after reset only captures the level (priming), so a
//               level already high at reset release never looks like a rise.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_db,
    output logic o_rise,
    output logic o_fall
);

    logic r_db_q;
    logic r_primed;

    // Track the previous level and mark the detector primed after one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_q   <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_db_q   <= i_db;
            r_primed <= 1'b1;
        end
    end

    assign o_rise = r_primed &  i_db & ~r_db_q;
    assign o_fall = r_primed & ~i_db &  r_db_q;

endmodule
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Classifies a debounced button level into single-cycle event
//               pulses: press, release, short press, long press and double
//               click. All pulses are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = ms_to_ticks(LONG_MS),   // >= 2
    parameter int unsigned DCLICK_TICKS = ms_to_ticks(DCLICK_MS)  // >= 2
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic press_tick,
    output logic release_tick,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam int unsigned c_max_ticks =
        (LONG_TICKS > DCLICK_TICKS) ? LONG_TICKS : DCLICK_TICKS;
    localparam int CNT_W = $clog2(c_max_ticks + 1);

    // Thresholds are compared one below the tick count because the counter
    // is cleared on the entry edge, so the transition edge lands exactly
    // TICKS cycles after the entry pulse.
    localparam logic [CNT_W-1:0] c_long_last   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] c_dclick_last = CNT_W'(DCLICK_TICKS - 1);

    logic             w_rise;
    logic             w_fall;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press_tick;
    logic             r_release_tick;
    logic             r_short_press;
    logic             r_long_press;
    logic             r_double_click;

    edge_detect u_edge_detect (
        .clk    (clk),
        .rst_n  (reset),
        .i_db   (db),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Gesture FSM with its dwell counter and registered event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_press_tick   <= 1'b0;
            r_release_tick <= 1'b0;
            r_short_press  <= 1'b0;
            r_long_press   <= 1'b0;
            r_double_click <= 1'b0;
        end else begin
            r_press_tick   <= 1'b0;
            r_release_tick <= 1'b0;
            r_short_press  <= 1'b0;
            r_long_press   <= 1'b0;
            r_double_click <= 1'b0;
            // Saturating count; any state change below overrides with a clear.
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    // A fall here is the release of a button held through reset.
                    if (w_rise) begin
                        r_state      <= PRESS1;
                        r_cnt        <= '0;
                        r_press_tick <= 1'b1;
                    end
                end
                PRESS1: begin
                    // Release beats the long threshold when both coincide.
                    if (w_fall) begin
                        r_state        <= WAIT2;
                        r_cnt          <= '0;
                        r_release_tick <= 1'b1;
                    end else if (r_cnt == c_long_last) begin
                        r_state      <= LONG;
                        r_cnt        <= '0;
                        r_long_press <= 1'b1;
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        r_state        <= IDLE;
                        r_cnt          <= '0;
                        r_release_tick <= 1'b1;
                    end
                end
                WAIT2: begin
                    // A second press on the timeout cycle still counts as a double click.
                    if (w_rise) begin
                        r_state        <= PRESS2;
                        r_cnt          <= '0;
                        r_press_tick   <= 1'b1;
                        r_double_click <= 1'b1;
                    end else if (r_cnt == c_dclick_last) begin
                        r_state       <= IDLE;
                        r_cnt         <= '0;
                        r_short_press <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (w_fall) begin
                        r_state        <= IDLE;
                        r_cnt          <= '0;
                        r_release_tick <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign press_tick   = r_press_tick;
    assign release_tick = r_release_tick;
    assign short_press  = r_short_press;
    assign long_press   = r_long_press;
    assign double_click = r_double_click;
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Directed bench for button_event_decoder with short tick
//               counts. Inputs change and outputs are sampled on negedge clk.
//               Output vector order: {press, release, short, long, dclick, busy}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic reset;
    logic db;
    logic press_tick;
    logic release_tick;
    logic short_press;
    logic long_press;
    logic double_click;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    wire [5:0] w_outs = {press_tick, release_tick, short_press,
                         long_press, double_click, busy};

    button_event_decoder #(
        .LONG_TICKS   (20),
        .DCLICK_TICKS (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .db           (db),
        .press_tick   (press_tick),
        .release_tick (release_tick),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] exp);
        n_tests++;
        assert (w_outs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, w_outs, exp);
        end
    endtask

    // Advance n cycles, checking the output vector after each posedge.
    task automatic cyc(input int n, input logic [5:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        db    = 1'b1;

        // Reset state, button held through reset
        @(negedge clk);
        check("reset_state", 6'b000000);
        @(negedge clk);
        reset = 1'b1;
        cyc(5, 6'b000000, "held_through_reset");
        db = 1'b0;
        cyc(5, 6'b000000, "held_release_ignored");

        // Short press: 5-cycle hold, short_press 10 cycles after release
        db = 1'b1;
        cyc(1, 6'b100001, "short_press_tick");
        cyc(4, 6'b000001, "short_hold");
        db = 1'b0;
        cyc(1, 6'b010001, "short_release_tick");
        cyc(9, 6'b000001, "short_wait");
        cyc(1, 6'b001000, "short_fire");
        cyc(3, 6'b000000, "short_idle");

        // Long press: 25-cycle hold, long_press 20 cycles after press_tick
        db = 1'b1;
        cyc(1, 6'b100001, "long_press_tick");
        cyc(19, 6'b000001, "long_hold");
        cyc(1, 6'b000101, "long_fire");
        cyc(4, 6'b000001, "long_held");
        db = 1'b0;
        cyc(1, 6'b010000, "long_release_tick");
        cyc(12, 6'b000000, "long_no_short");

        // Double click: press 3, release 4, press 3, release
        db = 1'b1;
        cyc(1, 6'b100001, "dc_press1");
        cyc(2, 6'b000001, "dc_hold1");
        db = 1'b0;
        cyc(1, 6'b010001, "dc_release1");
        cyc(3, 6'b000001, "dc_gap");
        db = 1'b1;
        cyc(1, 6'b100011, "dc_press2");
        cyc(2, 6'b000001, "dc_hold2");
        db = 1'b0;
        cyc(1, 6'b010000, "dc_release2");
        cyc(1, 6'b000000, "dc_busy_low");
        cyc(12, 6'b000000, "dc_no_short");

        // Second rise on the last WAIT2 cycle still wins
        db = 1'b1;
        cyc(1, 6'b100001, "edge_press1");
        cyc(1, 6'b000001, "edge_hold1");
        db = 1'b0;
        cyc(1, 6'b010001, "edge_release1");
        cyc(9, 6'b000001, "edge_wait");
        db = 1'b1;
        cyc(1, 6'b100011, "edge_dclick");
        cyc(1, 6'b000001, "edge_hold2");
        db = 1'b0;
        cyc(1, 6'b010000, "edge_release2");
        cyc(12, 6'b000000, "edge_no_short");

        // Rise one cycle after the timeout: short already fired, fresh press
        db = 1'b1;
        cyc(1, 6'b100001, "late_press1");
        cyc(1, 6'b000001, "late_hold1");
        db = 1'b0;
        cyc(1, 6'b010001, "late_release1");
        cyc(9, 6'b000001, "late_wait");
        cyc(1, 6'b001000, "late_short");
        db = 1'b1;
        cyc(1, 6'b100001, "late_new_press");
        db = 1'b0;
        cyc(1, 6'b010001, "late_release2");
        cyc(9, 6'b000001, "late_wait2");
        cyc(1, 6'b001000, "late_short2");

        // Reset 5 cycles into WAIT2 discards the pending short_press
        db = 1'b1;
        cyc(1, 6'b100001, "rst_press");
        cyc(1, 6'b000001, "rst_hold");
        db = 1'b0;
        cyc(1, 6'b010001, "rst_release");
        cyc(5, 6'b000001, "rst_wait");
        reset = 1'b0;
        #1;
        check("rst_async_clear", 6'b000000);
        cyc(2, 6'b000000, "rst_held");
        reset = 1'b1;
        cyc(20, 6'b000000, "rst_quiet");

        // Decoder works normally after the mid-gesture reset
        db = 1'b1;
        cyc(1, 6'b100001, "post_rst_press");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the early debouncer; consumes its clean level `db` in the same 100 MHz clk domain.
- Classifies activity into single-cycle event pulses: press, release, short press, long press, double click.
- Event pulses feed the system control FSM / LED logic; no further synchronisation is needed since `db` is already clk-synchronous.

Parameters:
- LONG_TICKS, 100_000_000, clk cycles a press must be held before long_press fires (1 s at 10 ns); must be >= 2.
- DCLICK_TICKS, 30_000_000, clk cycles after a release during which a second press counts as a double click (300 ms); must be >= 2.

Ports:
- clk  input  1  system clock, 10 ns period.
- reset  input  1  asynchronous, active-low reset.
- db  input  1  debounced button level from the debouncer; 1 = pressed.
- press_tick  output  1  one-cycle pulse on each accepted press.
- release_tick  output  1  one-cycle pulse on each accepted release.
- short_press  output  1  one-cycle pulse: single press released before LONG_TICKS, with no second press within DCLICK_TICKS.
- long_press  output  1  one-cycle pulse when a first press reaches LONG_TICKS.
- double_click  output  1  one-cycle pulse on the second press inside the window.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, all outputs 0, primed=0.
- Priming:
  - First clk edge after reset deassertion loads db_q <= db and sets primed.
  - No edge is generated on that cycle.
  - A button held through reset therefore produces no press_tick.
- Edge detection: rise = primed & db & ~db_q; fall = primed & ~db & db_q. db_q updates every cycle.
- All outputs are registered. Each pulse is high for exactly one cycle, on the edge after the cycle where the condition is sampled.
- Counter: unsigned, width $clog2(max(LONG_TICKS,DCLICK_TICKS)+1). Cleared on every state entry, +1 per cycle, saturates at all-ones.
- States and transitions:
  - IDLE:
    - rise -> PRESS1, press_tick.
    - fall ignored (covers held-through-reset release).
  - PRESS1:
    - fall -> WAIT2, release_tick. Fall takes priority over the long threshold.
    - Else if counter == LONG_TICKS-1 -> LONG, long_press.
    - Result: long_press lands exactly LONG_TICKS cycles after press_tick.
  - LONG:
    - fall -> IDLE, release_tick.
    - No short_press is issued.
  - WAIT2:
    - rise -> PRESS2, press_tick and double_click in the same cycle.
    - Else if counter == DCLICK_TICKS-1 -> IDLE, short_press.
    - Result: short_press lands exactly DCLICK_TICKS cycles after release_tick.
    - Simultaneous rise and timeout: the rise wins (double_click, no short_press).
  - PRESS2:
    - fall -> IDLE, release_tick.
    - Hold length is not classified; no long_press from a second press.
- At most one of short_press / long_press / double_click is asserted per gesture.
- press_tick and release_tick are never asserted in the same cycle.
- Reset mid-gesture: immediate return to IDLE, pending short_press discarded, priming repeats.

Decomposition:
- Shared package btn_pkg:
  - state enum btn_state_t {IDLE, PRESS1, LONG, WAIT2, PRESS2}.
  - Default tick constants CLK_HZ=100_000_000, LONG_MS=1000, DCLICK_MS=300, plus the ms-to-ticks function.
- Natural sub-module: edge_detect (db, primed logic, rise/fall outputs), reusable for the switch inputs.
- FSM and counter stay in this module.

Test Plan (LONG_TICKS=20, DCLICK_TICKS=10, edges on negedge clk):
- Reset released with db=1, drop db after 5 cycles -> no press_tick, no release_tick, busy stays 0.
- db=1 for 5 cycles, then 0 -> press_tick 1 cycle after rise; release_tick 1 cycle after fall; short_press exactly 10 cycles after release_tick; long_press and double_click stay 0.
- db=1 for 25 cycles -> long_press exactly 20 cycles after press_tick; release_tick on fall; short_press never asserted.
- Press 3, release 4, press 3, release -> second press_tick coincides with double_click. Then release_tick, busy 0 one cycle later, no short_press at any point.
- Second rise sampled on the WAIT2 cycle where counter==9 -> double_click=1, short_press=0. Rise one cycle later -> short_press already fired, new press_tick, no double_click.
- Assert reset 5 cycles into WAIT2, release with db=0 -> all outputs 0 for the next 20 cycles, busy=0.
